// File: rtl/param_counter_if.sv
// Control/status bundle for param_counter: the driver owns the controls,
// the counter owns the count, terminal-count and sticky boundary flag.
interface param_counter_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             up_down;
    logic             sat_mode;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             ovf;

    modport master (
        output enable, clear, load, load_val, up_down, sat_mode,
        input  out, tc, ovf
    );

    modport slave (
        input  enable, clear, load, load_val, up_down, sat_mode,
        output out, tc, ovf
    );
endinterface

// File: rtl/param_counter.sv
// Up/down counter over 0..MAX_VAL with wrap or saturate at the ends, clamped
// parallel load, a sticky boundary flag and a combinational cascade output.
module param_counter #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic                 clk,
    input  logic                 reset,
    param_counter_if.slave       bus
);
    logic [WIDTH-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;
    logic             at_max, at_zero;

    assign at_max  = (out_q == MAX_VAL);
    assign at_zero = (out_q == '0);

    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    always_comb begin
        out_d = out_q;
        ovf_d = ovf_q;
        if (bus.clear) begin
            out_d = '0;
            ovf_d = 1'b0;
        end else if (bus.load) begin
            out_d = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
        end else if (bus.enable) begin
            if (bus.up_down) begin
                if (at_max) begin
                    ovf_d = 1'b1;
                    out_d = bus.sat_mode ? MAX_VAL : '0;
                end else begin
                    out_d = out_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    ovf_d = 1'b1;
                    out_d = bus.sat_mode ? '0 : MAX_VAL;
                end else begin
                    out_d = out_q - WIDTH'(1);
                end
            end
        end
    end

    // NOTE: non-blocking assignments for state so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.out = out_q;
    assign bus.ovf = ovf_q;
    assign bus.tc  = bus.enable & ((bus.up_down & at_max) | (~bus.up_down & at_zero));
endmodule

// File: tb/tb_param_counter.sv
// Scoreboard bench for param_counter: two instances (4-bit/MAX 9 and 8-bit/MAX 255),
// directed boundary sequences plus randomized traffic against an arithmetic model.
module tb_param_counter;
    localparam int MAX_A = 9;
    localparam int MAX_B = 255;

    typedef struct {
        int out;
        bit ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    always #5 clk = ~clk;

    param_counter_if #(.WIDTH(4)) bus_a ();
    param_counter_if #(.WIDTH(8)) bus_b ();

    param_counter #(.WIDTH(4), .MAX_VAL(4'd9)) dut_a (
        .clk   (clk),
        .reset (rst_a_n),
        .bus   (bus_a)
    );

    param_counter #(.WIDTH(8), .MAX_VAL(8'd255)) dut_b (
        .clk   (clk),
        .reset (rst_b_n),
        .bus   (bus_b)
    );

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: plain integers, no width tricks.
    int m_out_a = 0;
    bit m_ovf_a = 0;
    int m_out_b = 0;
    bit m_ovf_b = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(input int max_val, inout int cnt, inout bit ovf,
                                       input bit en, input bit clr, input bit ld,
                                       input int lv, input bit up, input bit sat);
        if (clr) begin
            cnt = 0;
            ovf = 0;
        end else if (ld) begin
            cnt = (lv > max_val) ? max_val : lv;
        end else if (en) begin
            int nxt = up ? cnt + 1 : cnt - 1;
            if (nxt > max_val || nxt < 0) begin
                ovf = 1;
                if (!sat) cnt = (nxt < 0) ? max_val : 0;
            end else begin
                cnt = nxt;
            end
        end
    endfunction

    function automatic bit model_tc(input int max_val, input int cnt, input bit en, input bit up);
        return en && ((up && cnt == max_val) || (!up && cnt == 0));
    endfunction

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step_a(input bit en, input bit clr, input bit ld, input int lv,
                          input bit up, input bit sat);
        exp_t e;
        bus_a.enable   = en;
        bus_a.clear    = clr;
        bus_a.load     = ld;
        bus_a.load_val = 4'(lv);
        bus_a.up_down  = up;
        bus_a.sat_mode = sat;
        #1;
        check("tc_a", bus_a.tc, model_tc(MAX_A, m_out_a, en, up));
        model_step(MAX_A, m_out_a, m_ovf_a, en, clr, ld, lv, up, sat);
        e.out = m_out_a;
        e.ovf = m_ovf_a;
        q_a.push_back(e);
        @(negedge clk);
    endtask

    task automatic step_b(input bit en, input bit clr, input bit ld, input int lv,
                          input bit up, input bit sat);
        exp_t e;
        bus_b.enable   = en;
        bus_b.clear    = clr;
        bus_b.load     = ld;
        bus_b.load_val = 8'(lv);
        bus_b.up_down  = up;
        bus_b.sat_mode = sat;
        #1;
        check("tc_b", bus_b.tc, model_tc(MAX_B, m_out_b, en, up));
        model_step(MAX_B, m_out_b, m_ovf_b, en, clr, ld, lv, up, sat);
        e.out = m_out_b;
        e.ovf = m_ovf_b;
        q_b.push_back(e);
        @(negedge clk);
    endtask

    // Monitors: after each rising edge, compare whatever the stimulus predicted.
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check("out_a", bus_a.out, e.out);
            check("ovf_a", bus_a.ovf, e.ovf);
            check("range_a", bus_a.out <= 4'd9, 1'b1);
        end
    end

    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check("out_b", bus_b.out, e.out);
            check("ovf_b", bus_b.ovf, e.ovf);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        {bus_a.enable, bus_a.clear, bus_a.load, bus_a.up_down, bus_a.sat_mode} = '0;
        {bus_b.enable, bus_b.clear, bus_b.load, bus_b.up_down, bus_b.sat_mode} = '0;
        bus_a.load_val = '0;
        bus_b.load_val = '0;

        // Drive junk while in reset: must be ignored.
        #12;
        bus_a.enable = 1'b1;
        bus_a.load = 1'b1;
        bus_a.load_val = 4'd5;
        #13;
        check("reset_out_a", bus_a.out, 0);
        check("reset_ovf_a", bus_a.ovf, 0);
        check("reset_out_b", bus_b.out, 0);
        @(negedge clk);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        // Wrapping up-count through 9 -> 0.
        for (int i = 0; i < 12; i++) step_a(1, 0, 0, 0, 1, 0);
        check("wrap_end_a", bus_a.out, 2);
        check("wrap_ovf_a", bus_a.ovf, 1);

        // Load 7, saturating down-count into 0.
        step_a(0, 1, 0, 0, 1, 0);
        step_a(0, 0, 1, 7, 0, 1);
        for (int i = 0; i < 10; i++) step_a(1, 0, 0, 0, 0, 1);
        check("sat_end_a", bus_a.out, 0);

        // Clamp, load-over-enable, clear-over-load, load keeps ovf.
        step_a(0, 0, 1, 14, 1, 0);
        check("clamp_a", bus_a.out, 9);
        step_a(1, 0, 1, 3, 1, 0);
        step_a(1, 1, 1, 6, 1, 0);
        step_a(1, 0, 0, 0, 0, 0);
        step_a(1, 0, 0, 0, 1, 0);
        step_a(0, 0, 1, 4, 1, 0);
        step_a(0, 0, 0, 0, 0, 1);

        // Count to 5, then reset between edges.
        step_a(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step_a(1, 0, 0, 0, 1, 0);
        check("pre_reset_a", bus_a.out, 5);
        #2;
        rst_a_n = 1'b0;
        #1;
        check("async_out_a", bus_a.out, 0);
        check("async_ovf_a", bus_a.ovf, 0);
        m_out_a = 0;
        m_ovf_a = 0;
        bus_a.enable = 1'b1;
        bus_a.up_down = 1'b1;
        @(posedge clk);
        #1;
        check("held_reset_a", bus_a.out, 0);
        @(negedge clk);
        rst_a_n = 1'b1;
        for (int i = 0; i < 3; i++) step_a(1, 0, 0, 0, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 10000; i++) begin
            bit en  = ($urandom_range(99) < 70);
            bit clr = ($urandom_range(99) < 4);
            bit ld  = ($urandom_range(99) < 10);
            int lv  = int'($urandom_range(15));
            bit up  = 1'($urandom);
            bit sat = 1'($urandom);
            step_a(en, clr, ld, lv, up, sat);
        end

        // 8-bit natural wrap, then hold.
        for (int i = 0; i < 257; i++) step_b(1, 0, 0, 0, 1, 0);
        check("wrap_end_b", bus_b.out, 1);
        for (int i = 0; i < 5; i++) step_b(0, 0, 0, 0, 1, 0);
        check("hold_b", bus_b.out, 1);
        for (int i = 0; i < 500; i++) begin
            bit en  = ($urandom_range(99) < 80);
            bit clr = ($urandom_range(99) < 2);
            bit ld  = ($urandom_range(99) < 5);
            int lv  = int'($urandom_range(255));
            step_b(en, clr, ld, lv, 1'($urandom), 1'($urandom));
        end

        repeat (2) @(negedge clk);
        check("drain_a", q_a.size(), 0);
        check("drain_b", q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
